// File: rtl/gate3_sweep_pkg.sv
// Shared types and constants for the 3-input gate sweep checker.
package gate3_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [7:0] INIT_NAND3   = 8'h7F;
  localparam logic [7:0] INIT_NAND3B1 = 8'hBF;
  localparam logic [7:0] INIT_NAND3B2 = 8'hEF;
  localparam logic [7:0] INIT_NAND3B3 = 8'hFE;

  localparam int SETTLE_MAX = 15;

  // Reload value for the settle timer; out-of-range SETTLE is clamped to 1..SETTLE_MAX.
  function automatic logic [3:0] settle_load(input int settle);
    int s;
    s = settle;
    if (s < 1) s = 1;
    if (s > SETTLE_MAX) s = SETTLE_MAX;
    return 4'(s - 1);
  endfunction

endpackage

// File: rtl/gate3_settle_timer.sv
// Loadable 4-bit down-counter with terminal-count flag; holds at zero.
module gate3_settle_timer (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (rst)
      cnt <= 4'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/gate3_sweep_checker.sv
// Sweeps a 3-input gate through all 8 vectors and checks O against INIT.
// Define GATE3_SWEEP_XCHK_EN to count X/Z on O_FB as a mismatch.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for START; last result held
// ST_SETTLE  | vector driven, settle timer counting down
// ST_SAMPLE  | compare O_FB with INIT[vector], advance vector
// ST_FINISH  | publish DONE/PASS, drop BUSY
module gate3_sweep_checker
  import gate3_sweep_pkg::*;
#(
  parameter logic [7:0] INIT   = INIT_NAND3B2,
  parameter int         SETTLE = 2
) (
  input  logic       C,
  input  logic       R,
  input  logic       START,
  input  logic       O_FB,
  output logic       I0,
  output logic       I1,
  output logic       I2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FAIL_VEC
);

  localparam logic [3:0] SETTLE_LD = settle_load(SETTLE);

  state_t     state, state_nxt;
  logic [2:0] vec;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;
  logic       busy, done, pass;
  logic       accept, sample_en, finish_en, last_vec;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic       mismatch;

  always_ff @(posedge C) begin
    if (R)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (START) state_nxt = ST_SETTLE;
      ST_SETTLE: if (tmr_zero) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_vec ? ST_FINISH : ST_SETTLE;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    last_vec  = (vec == 3'd7);
    accept    = (state == ST_IDLE) && START;
    sample_en = (state == ST_SAMPLE);
    finish_en = (state == ST_FINISH);
    tmr_load  = accept || (sample_en && !last_vec);
    tmr_dec   = (state == ST_SETTLE);
  end

  gate3_settle_timer u_timer (
    .clk_sys  (C),
    .rst      (R),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef GATE3_SWEEP_XCHK_EN
  assign mismatch = (O_FB !== INIT[vec]);
`else
  // Only a definite opposite level counts; X/Z falls through as a match.
  assign mismatch = (O_FB === ~INIT[vec]);
`endif

  always_ff @(posedge C) begin
    if (R) begin
      vec      <= 3'd0;
      err_cnt  <= 4'd0;
      fail_vec <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      if (accept) begin
        vec      <= 3'd0;
        err_cnt  <= 4'd0;
        fail_vec <= 3'd0;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
      end
      if (sample_en) begin
        if (mismatch) begin
          err_cnt <= err_cnt + 4'd1;
          if (err_cnt == 4'd0) fail_vec <= vec;
        end
        if (!last_vec) vec <= vec + 3'd1;
      end
      if (finish_en) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_cnt == 4'd0);
      end
    end
  end

  assign I0       = vec[0];
  assign I1       = vec[1];
  assign I2       = vec[2];
  assign BUSY     = busy;
  assign DONE     = done;
  assign PASS     = pass;
  assign ERR_CNT  = err_cnt;
  assign FAIL_VEC = fail_vec;

endmodule

// File: tb/tb_gate3_sweep_checker.sv
// Self-checking bench for gate3_sweep_checker with a table-modelled gate on O_FB.
module tb_gate3_sweep_checker;

  typedef struct {
    logic [7:0] gate_tt;
    int         exp_err;
    int         exp_fv;
    int         exp_pass;
  } vec_t;

  typedef struct {
    int err;
    int fv;
    int pass;
  } res_t;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic       start = 1'b0;
  logic [7:0] gate_tt = 8'hEF;
  logic       o_fb;
  logic       i0, i1, i2, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  vec_t tbl[6];

  assign o_fb = gate_tt[{i2, i1, i0}];

  always #5 c = ~c;

  gate3_sweep_checker #(.INIT(8'hEF), .SETTLE(2)) dut (
    .C        (c),
    .R        (r),
    .START    (start),
    .O_FB     (o_fb),
    .I0       (i0),
    .I1       (i1),
    .I2       (i2),
    .BUSY     (busy),
    .DONE     (done),
    .PASS     (pass),
    .ERR_CNT  (err_cnt),
    .FAIL_VEC (fail_vec)
  );

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vec"}, int'({i2, i1, i0}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_cnt), 0);
    check({tag, "_fv"}, int'(fail_vec), 0);
  endtask

  // START at edge 0, then follow the sweep edge by edge until DONE.
  task automatic run_sweep(input vec_t v, input bit extra_start);
    res_t e, got;
    int   done_k;
    int   bad_vec;
    int   bad_busy;
    int   want_vec;
    gate_tt = v.gate_tt;
    e.err  = v.exp_err;
    e.fv   = v.exp_fv;
    e.pass = v.exp_pass;
    sb_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done_clr", int'(done), 0);
    done_k   = -1;
    bad_vec  = 0;
    bad_busy = 0;
    for (int k = 1; k <= 40; k++) begin
      start = extra_start && (k == 3 || k == 12);
      tick();
      start = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
      want_vec = (k / 3 > 7) ? 7 : k / 3;
      if (int'({i2, i1, i0}) != want_vec) bad_vec++;
      if (busy !== 1'b1) bad_busy++;
    end
    check("done_edge", done_k, 25);
    check("vec_sequence_errs", bad_vec, 0);
    check("busy_during_errs", bad_busy, 0);
    check("busy_after", int'(busy), 0);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      check("err_cnt", int'(err_cnt), got.err);
      check("fail_vec", int'(fail_vec), got.fv);
      check("pass", int'(pass), got.pass);
    end
    check("sb_drained", sb_q.size(), 0);
    for (int k = 0; k < 3; k++) tick();
    check("done_sticky", int'(done), 1);
    check("vec_hold7", int'({i2, i1, i0}), 7);
  endtask

  initial begin
    tbl[0] = '{8'hEF, 0, 0, 1};  // NAND3B2 gate, matches INIT
    tbl[1] = '{8'h7F, 2, 4, 0};  // NAND3: vectors 4 and 7 differ
    tbl[2] = '{8'h00, 7, 0, 0};  // tied low
    tbl[3] = '{8'hFF, 1, 4, 0};  // tied high
    tbl[4] = '{8'hFE, 2, 0, 0};  // NAND3B3: vectors 0 and 4 differ
    tbl[5] = '{8'h10, 8, 0, 0};  // fully inverted: maximum error count

    r = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    r = 1'b0;
    tick();

    foreach (tbl[i]) run_sweep(tbl[i], 1'b0);

    // Extra START pulses mid-sweep must not restart or double-report.
    run_sweep(tbl[1], 1'b1);

    // Reset at edge 10 of a sweep aborts it with no residue.
    gate_tt = 8'h00;
    sb_q.push_back('{7, 0, 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    check("mid_err_cnt", int'(err_cnt), 3);
    r = 1'b1;
    tick();
    r = 1'b0;
    check_reset_vals("abort");
    if (sb_q.size() != 0) sb_q.delete();
    tick();
    run_sweep(tbl[3], 1'b0);

    // START coincident with reset is ignored.
    r = 1'b1;
    start = 1'b1;
    tick();
    r = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("start_with_r_busy", int'(busy), 0);
    check("start_with_r_done", int'(done), 0);

    run_sweep(tbl[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
